// File: rtl/instr_queue_drain.sv
// instr_queue_drain: program-order circular buffer between decode (push side) and dispatch (pop side).
// Latency: an entry written at edge N is presented on pop_data_out in the cycle after edge N (no bypass).
// Backpressure: q_ready_out low when fewer than INSTR_Q_WIDTH slots are free; a push group that does not fit is dropped whole and flagged sticky.
//
// Ports:
//   clk_in, rst_in          clock, synchronous active-high reset (clears everything incl. overflow flag)
//   flush_in                mispredict flush: empties the queue next edge, discards same-cycle pushes
//   push_count_in/_data_in  up to INSTR_Q_WIDTH entries from decode, packed from slot 0 (oldest)
//   q_ready_out             at least INSTR_Q_WIDTH free slots, based on registered occupancy
//   pop_req_in              entries dispatch can take this cycle
//   pop_count_out/_data_out entries actually dequeued this cycle, slot 0 = head; unused slots are zero
//   count_out               registered occupancy
//   overflow_err_out        sticky: a push group was dropped

package instr_queue_pkg;
  typedef struct packed {
    logic [7:0]  tag;
    logic [31:0] insn;
  } uop_insn;
endpackage

module instr_queue_drain
  import instr_queue_pkg::*;
#(
  parameter int INSTR_Q_DEPTH = 16,
  parameter int INSTR_Q_WIDTH = 4,
  parameter int POP_WIDTH     = 4
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic                               flush_in,
  input  logic [$clog2(INSTR_Q_WIDTH+1)-1:0] push_count_in,
  input  uop_insn                            push_data_in [INSTR_Q_WIDTH],
  output logic                               q_ready_out,
  input  logic [$clog2(POP_WIDTH+1)-1:0]     pop_req_in,
  output logic [$clog2(POP_WIDTH+1)-1:0]     pop_count_out,
  output uop_insn                            pop_data_out [POP_WIDTH],
  output logic [$clog2(INSTR_Q_DEPTH+1)-1:0] count_out,
  output logic                               overflow_err_out
);

  localparam int PTR_W = $clog2(INSTR_Q_DEPTH);
  localparam int CNT_W = $clog2(INSTR_Q_DEPTH+1);
  localparam int POP_W = $clog2(POP_WIDTH+1);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(INSTR_Q_DEPTH);
  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(INSTR_Q_WIDTH);

  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  uop_insn          mem_q [INSTR_Q_DEPTH];

  logic             quiesce;
  logic [CNT_W-1:0] free_slots;
  logic [CNT_W-1:0] push_cnt_w;
  logic [CNT_W-1:0] pop_req_w;
  logic [CNT_W-1:0] pop_cnt_w;
  logic [CNT_W-1:0] push_acc_w;
  logic             push_fits;
  logic             push_do;
  logic             push_drop;

  // Counts are compared at occupancy width; DEPTH >= 2*WIDTH and POP_WIDTH <= DEPTH
  // guarantee the zero-extensions below never truncate.
  always_comb begin
    quiesce    = rst_in | flush_in;
    free_slots = DEPTH_C - count_q;
    push_cnt_w = CNT_W'(push_count_in);
    pop_req_w  = CNT_W'(pop_req_in);
    // Acceptance looks only at start-of-cycle occupancy; same-cycle pops never
    // make room for same-cycle pushes. Out-of-range counts are rejected.
    push_fits  = (push_cnt_w <= WIDTH_C) && (push_cnt_w <= free_slots);
    push_do    = !quiesce && push_fits && (push_cnt_w != '0);
    push_drop  = !quiesce && !push_fits;
    push_acc_w = push_do ? push_cnt_w : '0;
    pop_cnt_w  = '0;
    if (!quiesce) begin
      pop_cnt_w = (pop_req_w < count_q) ? pop_req_w : count_q;
    end
  end

  assign pop_count_out    = POP_W'(pop_cnt_w);
  assign count_out        = count_q;
  assign overflow_err_out = overflow_q;
  assign q_ready_out      = (free_slots >= WIDTH_C);

  // Pointer sums wrap naturally because DEPTH is a power of two.
  always_comb begin
    for (int i = 0; i < POP_WIDTH; i++) begin
      pop_data_out[i] = '0;
      if (CNT_W'(i) < pop_cnt_w) begin
        pop_data_out[i] = mem_q[head_q + PTR_W'(i)];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (flush_in) begin
      // Flush keeps the sticky error so software can still see a dropped group.
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + PTR_W'(pop_cnt_w);
      tail_q  <= tail_q + PTR_W'(push_acc_w);
      count_q <= count_q + push_acc_w - pop_cnt_w;
      if (push_drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Storage is not reset: stale entries are unreachable once the pointers/count clear.
  always_ff @(posedge clk_in) begin
    if (push_do) begin
      for (int i = 0; i < INSTR_Q_WIDTH; i++) begin
        if (CNT_W'(i) < push_cnt_w) begin
          mem_q[tail_q + PTR_W'(i)] <= push_data_in[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_queue_drain.sv
// tb_instr_queue_drain: directed stimulus with a pop-data scoreboard for instr_queue_drain.
// Latency: inputs applied 1 time unit after each rising edge, outputs sampled on the falling edge.
// Backpressure: expected accepted entries are queued at issue; a monitor pops them as the DUT dequeues.

module tb_instr_queue_drain;
  import instr_queue_pkg::*;

  localparam int D = 16;
  localparam int W = 4;
  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst_in = 1'b1;
  logic       flush_in = 1'b0;
  logic [2:0] push_count_in = '0;
  uop_insn    push_data_in [W];
  logic       q_ready_out;
  logic [2:0] pop_req_in = '0;
  logic [2:0] pop_count_out;
  uop_insn    pop_data_out [P];
  logic [4:0] count_out;
  logic       overflow_err_out;

  int      n_cmp = 0;
  int      n_bad = 0;
  uop_insn exp_q [$];
  uop_insn mon_e;

  instr_queue_drain #(
    .INSTR_Q_DEPTH(D),
    .INSTR_Q_WIDTH(W),
    .POP_WIDTH    (P)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst_in),
    .flush_in        (flush_in),
    .push_count_in   (push_count_in),
    .push_data_in    (push_data_in),
    .q_ready_out     (q_ready_out),
    .pop_req_in      (pop_req_in),
    .pop_count_out   (pop_count_out),
    .pop_data_out    (pop_data_out),
    .count_out       (count_out),
    .overflow_err_out(overflow_err_out)
  );

  always #5 clk = ~clk;

  function automatic uop_insn mk(input int t);
    uop_insn u;
    u.tag  = t[7:0];
    u.insn = 32'hC0DE_0000 | {24'h0, t[7:0]};
    return u;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Apply one cycle of inputs and wait for the sampling point of that cycle.
  task automatic drive(input int pc, input int t0, input int pr,
                       input bit fl, input bit rs, input bit expect_accept);
    push_count_in = 3'(pc);
    for (int i = 0; i < W; i++) begin
      push_data_in[i] = (i < pc) ? mk(t0 + i) : '0;
    end
    if (expect_accept) begin
      for (int i = 0; i < pc; i++) exp_q.push_back(mk(t0 + i));
    end
    pop_req_in = 3'(pr);
    flush_in   = fl;
    rst_in     = rs;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every dequeued slot must match the scoreboard head; idle slots must be zero.
  always @(negedge clk) begin
    for (int i = 0; i < P; i++) begin
      n_cmp++;
      if (i < int'(pop_count_out)) begin
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL pop_data[%0d]: got %h, expected no entry", i, pop_data_out[i]);
        end else begin
          mon_e = exp_q.pop_front();
          if (pop_data_out[i] !== mon_e) begin
            n_bad++;
            $display("FAIL pop_data[%0d]: got %h, expected %h", i, pop_data_out[i], mon_e);
          end
        end
      end else if (pop_data_out[i] !== '0) begin
        n_bad++;
        $display("FAIL pop_zero[%0d]: got %h, expected 0", i, pop_data_out[i]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

  initial begin
    int drn_cnt [4];
    int drn_pop [4];
    drn_cnt = '{14, 10, 6, 2};
    drn_pop = '{4, 4, 4, 2};
    for (int i = 0; i < W; i++) push_data_in[i] = '0;

    // Reset values
    drive(0, 0, 0, 0, 1, 0);
    tick();
    drive(0, 0, 4, 0, 1, 0);
    chk("rst_count", count_out, 0);
    chk("rst_ready", q_ready_out, 1);
    chk("rst_popcnt", pop_count_out, 0);
    chk("rst_ovf", overflow_err_out, 0);
    tick();

    // Push A,B,C then pop with request 4
    drive(3, 'hA0, 0, 0, 0, 1);
    chk("abc_cnt0", count_out, 0);
    tick();
    drive(0, 0, 4, 0, 0, 0);
    chk("abc_cnt", count_out, 3);
    chk("abc_ready", q_ready_out, 1);
    chk("abc_popcnt", pop_count_out, 3);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("abc_empty", count_out, 0);
    tick();

    // Fill to 16, then an extra push is rejected
    for (int k = 0; k < 4; k++) begin
      drive(4, 'hB0 + 4 * k, 0, 0, 0, 1);
      chk("fill_cnt", count_out, 4 * k);
      chk("fill_ready", q_ready_out, 1);
      tick();
    end
    drive(1, 'hC0, 0, 0, 0, 0);
    chk("full_cnt", count_out, 16);
    chk("full_ready", q_ready_out, 0);
    chk("full_ovf_pre", overflow_err_out, 0);
    tick();
    // Full: pop honoured, push still rejected
    drive(1, 'hC1, 4, 0, 0, 0);
    chk("full_hold", count_out, 16);
    chk("full_ovf", overflow_err_out, 1);
    chk("full_popcnt", pop_count_out, 4);
    tick();

    // Simultaneous push 4 / pop 2 at count 12
    drive(4, 'hD0, 2, 0, 0, 1);
    chk("sim_cnt", count_out, 12);
    chk("sim_ready", q_ready_out, 1);
    chk("sim_popcnt", pop_count_out, 2);
    tick();

    // Drain 14 entries (head ends at 7)
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 4, 0, 0, 0);
      chk("drain_cnt", count_out, drn_cnt[k]);
      chk("drain_popcnt", pop_count_out, drn_pop[k]);
      if (k == 0) chk("drain_ready", q_ready_out, 0);
      tick();
    end

    // Move head/tail to 14; empty queue ignores pop requests
    drive(4, 'hE0, 4, 0, 0, 1);
    chk("empty_cnt", count_out, 0);
    chk("empty_popcnt", pop_count_out, 0);
    chk("ovf_sticky", overflow_err_out, 1);
    tick();
    drive(3, 'hE4, 4, 0, 0, 1);
    chk("adv_cnt", count_out, 4);
    chk("adv_popcnt", pop_count_out, 4);
    tick();
    drive(0, 0, 4, 0, 0, 0);
    chk("adv2_cnt", count_out, 3);
    chk("adv2_popcnt", pop_count_out, 3);
    tick();

    // Wrap: W,X,Y,Z land in slots 14,15,0,1
    drive(4, 'hF0, 0, 0, 0, 1);
    chk("wrap_cnt0", count_out, 0);
    tick();
    drive(0, 0, 4, 0, 0, 0);
    chk("wrap_cnt", count_out, 4);
    chk("wrap_popcnt", pop_count_out, 4);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("wrap_empty", count_out, 0);
    tick();

    // Flush at count 9 with push and pop requested
    drive(4, 'h50, 0, 0, 0, 1);
    tick();
    drive(4, 'h54, 0, 0, 0, 1);
    chk("fl_cnt4", count_out, 4);
    tick();
    drive(1, 'h58, 0, 0, 0, 1);
    chk("fl_cnt8", count_out, 8);
    tick();
    drive(4, 'h5C, 4, 1, 0, 0);
    chk("fl_cnt9", count_out, 9);
    chk("fl_popcnt", pop_count_out, 0);
    exp_q.delete();
    tick();
    drive(0, 0, 4, 0, 0, 0);
    chk("fl_after_cnt", count_out, 0);
    chk("fl_after_ready", q_ready_out, 1);
    chk("fl_after_ovf", overflow_err_out, 1);
    chk("fl_after_popcnt", pop_count_out, 0);
    tick();

    // Reset mid-operation at count 7 with overflow set
    drive(4, 'h60, 0, 0, 0, 1);
    tick();
    drive(3, 'h64, 0, 0, 0, 1);
    tick();
    drive(4, 'h68, 4, 1, 1, 0);
    chk("mrst_cnt", count_out, 7);
    chk("mrst_ovf", overflow_err_out, 1);
    chk("mrst_popcnt", pop_count_out, 0);
    exp_q.delete();
    tick();
    drive(1, 'h70, 0, 0, 0, 1);
    chk("mrst_after_cnt", count_out, 0);
    chk("mrst_after_ready", q_ready_out, 1);
    chk("mrst_after_ovf", overflow_err_out, 0);
    chk("mrst_after_popcnt", pop_count_out, 0);
    tick();
    drive(0, 0, 4, 0, 0, 0);
    chk("post_rst_cnt", count_out, 1);
    chk("post_rst_popcnt", pop_count_out, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("post_rst_empty", count_out, 0);
    chk("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
